// File: rtl/fuzzy_rule_sequencer.sv
// Sequences one interval type-2 fuzzy inference: clears the rule memory, walks the rules
// with a req/ack handshake, aggregates firing strengths per consequent set, then runs the defuzzifier.
module fuzzy_rule_sequencer #(
   parameter int N_RULES     = 9,
   parameter int ACK_TIMEOUT = 64
) (
   input  logic       clk_0,
   input  logic       Srst,
   input  logic       start,
   input  logic [7:0] Entrada_01,
   input  logic [7:0] Entrada_02,
   output logic [7:0] ent_01_q,
   output logic [7:0] ent_02_q,
   output logic       reset_mem,
   output logic [3:0] rule_idx,
   output logic       rule_req,
   input  logic       rule_ack,
   input  logic [7:0] rule_up,
   input  logic [7:0] rule_low,
   input  logic [1:0] rule_cons,
   output logic [7:0] fou_up_0,
   output logic [7:0] fou_up_1,
   output logic [7:0] fou_up_2,
   output logic [7:0] fou_low_0,
   output logic [7:0] fou_low_1,
   output logic [7:0] fou_low_2,
   output logic       defuzz_start,
   input  logic       defuzz_done,
   input  logic [7:0] defuzz_in,
   output logic [7:0] saida,
   output logic       saida_valid,
   output logic       busy,
   output logic       error
);

   // state  | meaning
   // IDLE   | waiting for start, result and error held
   // CLEAR  | reset_mem pulse, aggregates and rule index zeroed
   // ISSUE  | rule_req pulse for rule_idx
   // WAIT   | waiting for rule_ack, timeout counting
   // DEFUZZ | defuzz_start pulse
   // DWAIT  | waiting for defuzz_done, timeout counting
   // ERR    | timeout seen, one cycle then IDLE
   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_ISSUE, S_WAIT, S_DEFUZZ, S_DWAIT, S_ERR
   } state_t;

   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [3:0]    LAST_IDX = 4'(N_RULES - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

   state_t              state_q, state_d;
   logic [3:0]          idx_q, idx_d;
   logic [TW-1:0]       tmo_q, tmo_d;
   logic [7:0]          ent1_q, ent1_d, ent2_q, ent2_d;
   logic [2:0][7:0]     up_q, up_d, low_q, low_d;
   logic [7:0]          saida_q, saida_d;
   logic                sv_q, sv_d;
   logic                err_q, err_d;
   logic [7:0]          low_eff;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      tmo_d   = tmo_q;
      ent1_d  = ent1_q;
      ent2_d  = ent2_q;
      up_d    = up_q;
      low_d   = low_q;
      saida_d = saida_q;
      sv_d    = 1'b0;
      err_d   = err_q;
      // the lower strength can never exceed the upper one of the same rule
      low_eff = (rule_low < rule_up) ? rule_low : rule_up;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               ent1_d  = Entrada_01;
               ent2_d  = Entrada_02;
               err_d   = 1'b0;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            up_d    = '0;
            low_d   = '0;
            idx_d   = '0;
            state_d = S_ISSUE;
         end
         S_ISSUE: begin
            tmo_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (rule_ack) begin
               for (int c = 0; c < 3; c++) begin
                  if (rule_cons == 2'(c)) begin
                     if (rule_up > up_q[c]) up_d[c] = rule_up;
                     if (low_eff > low_q[c]) low_d[c] = low_eff;
                  end
               end
               if (idx_q == LAST_IDX) begin
                  state_d = S_DEFUZZ;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = S_ISSUE;
               end
            end else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = S_ERR;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         S_DEFUZZ: begin
            tmo_d   = '0;
            state_d = S_DWAIT;
         end
         S_DWAIT: begin
            if (defuzz_done) begin
               saida_d = defuzz_in;
               sv_d    = 1'b1;
               state_d = S_IDLE;
            end else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = S_ERR;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         S_ERR: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_0) begin
      if (Srst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         tmo_q   <= '0;
         ent1_q  <= '0;
         ent2_q  <= '0;
         up_q    <= '0;
         low_q   <= '0;
         saida_q <= '0;
         sv_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         tmo_q   <= tmo_d;
         ent1_q  <= ent1_d;
         ent2_q  <= ent2_d;
         up_q    <= up_d;
         low_q   <= low_d;
         saida_q <= saida_d;
         sv_q    <= sv_d;
         err_q   <= err_d;
      end
   end

   assign reset_mem    = (state_q == S_CLEAR);
   assign rule_req     = (state_q == S_ISSUE);
   assign defuzz_start = (state_q == S_DEFUZZ);
   assign busy         = (state_q != S_IDLE);
   assign saida_valid  = sv_q;
   assign saida        = saida_q;
   assign error        = err_q;
   assign rule_idx     = idx_q;
   assign ent_01_q     = ent1_q;
   assign ent_02_q     = ent2_q;
   assign fou_up_0     = up_q[0];
   assign fou_up_1     = up_q[1];
   assign fou_up_2     = up_q[2];
   assign fou_low_0    = low_q[0];
   assign fou_low_1    = low_q[1];
   assign fou_low_2    = low_q[2];

endmodule

// File: tb/tb_fuzzy_rule_sequencer.sv
// Scoreboard bench for fuzzy_rule_sequencer: directed inferences push expected results,
// a monitor pops and checks them on every saida_valid.
module tb_fuzzy_rule_sequencer;

   typedef struct packed {
      logic [7:0] s;
      logic [7:0] u0, u1, u2, l0, l1, l2;
   } exp_t;

   logic       clk_0, Srst, start;
   logic [7:0] Entrada_01, Entrada_02, ent_01_q, ent_02_q;
   logic       reset_mem, rule_req, rule_ack, defuzz_start, defuzz_done;
   logic [3:0] rule_idx;
   logic [7:0] rule_up, rule_low, defuzz_in, saida;
   logic [1:0] rule_cons;
   logic [7:0] fou_up_0, fou_up_1, fou_up_2, fou_low_0, fou_low_1, fou_low_2;
   logic       saida_valid, busy, error;

   logic       r_ack, s_ack;
   logic [7:0] r_up, r_low;
   logic [1:0] r_cons;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_dz  = 0;
   int   mode  = 0;
   int   withhold = -1;
   logic [7:0] dz_val = 8'h00;
   exp_t exp_q[$];
   exp_t e_mon;

   assign rule_ack  = r_ack | s_ack;
   assign rule_up   = s_ack ? 8'd255 : r_up;
   assign rule_low  = s_ack ? 8'd255 : r_low;
   assign rule_cons = s_ack ? 2'd0   : r_cons;

   fuzzy_rule_sequencer #(.N_RULES(9), .ACK_TIMEOUT(64)) dut (
      .clk_0(clk_0), .Srst(Srst), .start(start),
      .Entrada_01(Entrada_01), .Entrada_02(Entrada_02),
      .ent_01_q(ent_01_q), .ent_02_q(ent_02_q),
      .reset_mem(reset_mem), .rule_idx(rule_idx), .rule_req(rule_req),
      .rule_ack(rule_ack), .rule_up(rule_up), .rule_low(rule_low), .rule_cons(rule_cons),
      .fou_up_0(fou_up_0), .fou_up_1(fou_up_1), .fou_up_2(fou_up_2),
      .fou_low_0(fou_low_0), .fou_low_1(fou_low_1), .fou_low_2(fou_low_2),
      .defuzz_start(defuzz_start), .defuzz_done(defuzz_done), .defuzz_in(defuzz_in),
      .saida(saida), .saida_valid(saida_valid), .busy(busy), .error(error)
   );

   initial begin
      clk_0 = 1'b0;
      forever #5 clk_0 = ~clk_0;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // rule evaluator model: answers each rule_req on the first WAIT cycle
   initial begin
      int k;
      r_ack = 1'b0; r_up = '0; r_low = '0; r_cons = '0;
      forever begin
         @(negedge clk_0);
         if (rule_req && !Srst && int'(rule_idx) != withhold) begin
            k = int'(rule_idx);
            @(posedge clk_0); #1;
            r_ack = 1'b1;
            case (mode)
               1:       begin r_up = 8'd100;     r_low = 8'd200;    r_cons = 2'd0; end
               2:       begin r_up = 8'(10 * k); r_low = 8'(5 * k); r_cons = 2'd3; end
               3:       begin r_up = 8'(20 * k); r_low = 8'd100;    r_cons = (k < 4) ? 2'd1 : 2'd2; end
               default: begin r_up = 8'(10 * k); r_low = 8'(5 * k); r_cons = 2'(k % 3); end
            endcase
            @(posedge clk_0); #1;
            r_ack = 1'b0;
            r_cons = 2'd3;
         end
      end
   end

   // defuzzifier model
   initial begin
      defuzz_done = 1'b0; defuzz_in = '0;
      forever begin
         @(negedge clk_0);
         if (defuzz_start && !Srst) begin
            @(posedge clk_0); #1;
            defuzz_done = 1'b1; defuzz_in = dz_val;
            @(posedge clk_0); #1;
            defuzz_done = 1'b0; defuzz_in = 8'hEE;
         end
      end
   end

   always @(negedge clk_0) begin
      if (defuzz_start) n_dz++;
      if (int'(reset_mem) + int'(rule_req) + int'(defuzz_start) + int'(saida_valid) > 1) begin
         n_bad++;
         $display("FAIL pulse_overlap: rm=%0b rq=%0b ds=%0b sv=%0b", reset_mem, rule_req, defuzz_start, saida_valid);
      end
      if (saida_valid) begin
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_saida_valid: saida=%0d, expected no result", saida);
         end else begin
            e_mon = exp_q.pop_front();
            chk("saida", 32'(saida), 32'(e_mon.s));
            chk("fou_up_0", 32'(fou_up_0), 32'(e_mon.u0));
            chk("fou_up_1", 32'(fou_up_1), 32'(e_mon.u1));
            chk("fou_up_2", 32'(fou_up_2), 32'(e_mon.u2));
            chk("fou_low_0", 32'(fou_low_0), 32'(e_mon.l0));
            chk("fou_low_1", 32'(fou_low_1), 32'(e_mon.l1));
            chk("fou_low_2", 32'(fou_low_2), 32'(e_mon.l2));
         end
      end
   end

   // issue one inference; lat = cycle (start cycle = 0) of saida_valid or of ERR
   task automatic run(input int md, input logic [7:0] dz, input logic [7:0] e1, input logic [7:0] e2,
                      input exp_t ex, input bit push, input bit poke_start, output int lat);
      mode = md; dz_val = dz;
      if (push) exp_q.push_back(ex);
      @(posedge clk_0); #1;
      Entrada_01 = e1; Entrada_02 = e2; start = 1'b1;
      @(posedge clk_0); #1;
      start = 1'b0; Entrada_01 = ~e1; Entrada_02 = ~e2;
      lat = -1;
      for (int i = 0; i < 300; i++) begin
         if (saida_valid || (error && busy)) begin
            lat = i + 1;
            break;
         end
         if (i == 0) chk("error_cleared_on_start", 32'(error), 0);
         if (i == 1) begin
            chk("first_issue_req", 32'(rule_req), 1);
            chk("first_issue_idx", 32'(rule_idx), 0);
         end
         if (i == 3) begin
            chk("ent_01_latched", 32'(ent_01_q), 32'(e1));
            chk("ent_02_latched", 32'(ent_02_q), 32'(e2));
         end
         if (poke_start && i == 4) start = 1'b1;
         if (i == 5) start = 1'b0;
         @(posedge clk_0); #1;
      end
      if (lat < 0) begin
         n_bad++;
         $display("FAIL run_timeout: no saida_valid or error within 300 cycles (mode %0d)", md);
      end
   endtask

   initial begin
      int lat;
      int dz0;
      Srst = 1'b1; start = 1'b0; Entrada_01 = '0; Entrada_02 = '0; s_ack = 1'b0;
      repeat (3) @(posedge clk_0);
      #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_error", 32'(error), 0);
      chk("rst_rule_idx", 32'(rule_idx), 0);
      chk("rst_saida", 32'(saida), 0);
      chk("rst_fou_up_0", 32'(fou_up_0), 0);
      Srst = 1'b0;
      @(posedge clk_0); #1;
      chk("post_rst_pulses", 32'({reset_mem, rule_req, defuzz_start, saida_valid}), 0);

      // base pattern: up=10k, low=5k, cons=k mod 3
      run(0, 8'h5A, 8'h12, 8'h34, '{8'h5A, 8'd60, 8'd70, 8'd80, 8'd30, 8'd35, 8'd40}, 1, 0, lat);
      chk("latency_base", 32'(lat), 22);

      // stray ack in IDLE must not touch aggregates
      @(posedge clk_0); #1; s_ack = 1'b1;
      @(posedge clk_0); #1; s_ack = 1'b0;
      chk("idle_ack_up0", 32'(fou_up_0), 60);
      chk("idle_ack_low0", 32'(fou_low_0), 30);
      chk("idle_ack_busy", 32'(busy), 0);
      chk("saida_held", 32'(saida), 32'h5A);

      // low above up is clamped to up
      run(1, 8'h11, 8'hA0, 8'h0B, '{8'h11, 8'd100, 8'd0, 8'd0, 8'd100, 8'd0, 8'd0}, 1, 0, lat);
      chk("latency_clamp", 32'(lat), 22);

      // no consequents: aggregates stay 0 but defuzz still runs
      dz0 = n_dz;
      run(2, 8'h77, 8'h01, 8'h02, '{8'h77, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 1, 0, lat);
      chk("latency_nocons", 32'(lat), 22);
      chk("defuzz_issued_nocons", 32'(n_dz - dz0), 1);

      // mixed pattern with start poked during WAIT
      run(3, 8'hC3, 8'hFF, 8'h00, '{8'hC3, 8'd0, 8'd60, 8'd160, 8'd0, 8'd60, 8'd100}, 1, 1, lat);
      chk("latency_poke", 32'(lat), 22);

      // ack withheld on rule 4: 64 WAIT cycles then ERR
      withhold = 4;
      run(0, 8'h99, 8'h55, 8'h66, '0, 0, 0, lat);
      chk("timeout_cycle", 32'(lat), 75);
      chk("err_flag", 32'(error), 1);
      @(posedge clk_0); #1;
      chk("err_busy_next", 32'(busy), 0);
      chk("err_sticky", 32'(error), 1);
      chk("err_saida_kept", 32'(saida), 32'hC3);
      withhold = -1;
      run(0, 8'h5A, 8'h21, 8'h43, '{8'h5A, 8'd60, 8'd70, 8'd80, 8'd30, 8'd35, 8'd40}, 1, 0, lat);
      chk("latency_after_err", 32'(lat), 22);

      // synchronous reset in the middle of WAIT at rule 5
      mode = 0;
      @(posedge clk_0); #1; Entrada_01 = 8'h3C; start = 1'b1;
      @(posedge clk_0); #1; start = 1'b0;
      lat = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_0);
         if (rule_req && rule_idx == 4'd5) begin lat = i; break; end
      end
      chk("reached_rule5", 32'(lat >= 0), 1);
      @(posedge clk_0); #1; Srst = 1'b1;
      @(posedge clk_0); #1; Srst = 1'b0;
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_idx", 32'(rule_idx), 0);
      chk("mid_rst_up0", 32'(fou_up_0), 0);
      chk("mid_rst_low2", 32'(fou_low_2), 0);
      chk("mid_rst_ent1", 32'(ent_01_q), 0);
      chk("mid_rst_saida", 32'(saida), 0);
      chk("mid_rst_pulses", 32'({reset_mem, rule_req, defuzz_start, saida_valid, error}), 0);
      run(0, 8'h42, 8'h7E, 8'h81, '{8'h42, 8'd60, 8'd70, 8'd80, 8'd30, 8'd35, 8'd40}, 1, 0, lat);
      chk("latency_after_rst", 32'(lat), 22);

      repeat (3) @(posedge clk_0);
      #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
